// File: rtl/sent_cfg_scheduler_pkg.sv
// rtl/sent_cfg_scheduler_pkg.sv - shared record layout, FSM encoding and validation limits
package sent_cfg_scheduler_pkg;

  // Record widths: a FIFO entry is {channel, param}
  localparam int PARAM_W = 66;
  localparam int CH_W    = 8;
  localparam int REC_W   = CH_W + PARAM_W;

  // Field offsets inside the 66-bit param record
  localparam int CTICK_LSB  = 58;  // [65:58]
  localparam int LTICK_LSB  = 50;  // [57:50]
  localparam int PMODE_LSB  = 48;  // [49:48]
  localparam int PLEN_LSB   = 32;  // [47:32]
  localparam int CRC_BIT    = 31;  // [31]
  localparam int STATUS_LSB = 27;  // [30:27]
  localparam int DLEN_LSB   = 24;  // [26:24]
  localparam int DATA_LSB   = 0;   // [23:0]

  // Validation limits
  localparam logic [7:0]  CTICK_MIN = 8'd3;
  localparam logic [7:0]  CTICK_MAX = 8'd90;
  localparam logic [7:0]  LTICK_MIN = 8'd4;
  localparam logic [2:0]  DLEN_MIN  = 3'd1;
  localparam logic [2:0]  DLEN_MAX  = 3'd6;
  localparam logic [15:0] PLEN_MIN  = 16'd12;
  localparam logic [15:0] PLEN_MAX  = 16'd768;
  localparam logic [1:0]  PMODE_FIXED   = 2'd1;
  localparam logic [1:0]  PMODE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  // Increment that sticks at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sent_cfg_fifo.sv
// rtl/sent_cfg_fifo.sv - synchronous record FIFO with full/empty flags and same-cycle read/write
module sent_cfg_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 4   // power of 2, at least 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_wr, do_rd;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a write
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sent_cfg_scheduler.sv
// rtl/sent_cfg_scheduler.sv - validates SENT config records, queues them and reloads channels at frame boundaries
module sent_cfg_scheduler
  import sent_cfg_scheduler_pkg::*;
#(
  parameter int CH_NUM      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_vld,
  input  logic [CH_W-1:0]    cfg_channel,
  input  logic [PARAM_W-1:0] cfg_param,
  input  logic [CH_NUM-1:0]  ch_ready,
  output logic [CH_NUM-1:0]  ch_load,
  output logic [PARAM_W-1:0] ch_param,
  output logic               busy,
  output logic [15:0]        err_cnt,
  output logic [15:0]        ovf_cnt,
  output logic [15:0]        tmo_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     hold_ch_q;
  logic [PARAM_W-1:0]  hold_param_q, ch_param_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [15:0]         err_q, ovf_q, tmo_q;

  logic [CH_W-1:0]     head_ch;
  logic [PARAM_W-1:0]  head_param;
  logic                fifo_full, fifo_empty;
  logic                rec_ok, push, pop;
  logic [CH_NUM-1:0]   hold_oh;
  logic                ready_sel, wait_last, timeout;

  // Field views of the incoming record
  logic [7:0]  f_ctick, f_ltick;
  logic [1:0]  f_pmode;
  logic [15:0] f_plen;
  logic [2:0]  f_dlen;
  logic        ch_ok, tick_ok, dlen_ok, pause_ok;

  assign f_ctick = cfg_param[CTICK_LSB +: 8];
  assign f_ltick = cfg_param[LTICK_LSB +: 8];
  assign f_pmode = cfg_param[PMODE_LSB +: 2];
  assign f_plen  = cfg_param[PLEN_LSB +: 16];
  assign f_dlen  = cfg_param[DLEN_LSB +: 3];

  assign ch_ok    = ({24'd0, cfg_channel} < 32'(CH_NUM));
  assign tick_ok  = (f_ctick >= CTICK_MIN) && (f_ctick <= CTICK_MAX) && (f_ltick >= LTICK_MIN);
  assign dlen_ok  = (f_dlen >= DLEN_MIN) && (f_dlen <= DLEN_MAX);
  // Pause length only matters in fixed-pause mode
  assign pause_ok = (f_pmode != PMODE_ILLEGAL) &&
                    !((f_pmode == PMODE_FIXED) && ((f_plen < PLEN_MIN) || (f_plen > PLEN_MAX)));
  assign rec_ok   = cfg_vld && ch_ok && tick_ok && dlen_ok && pause_ok;

  assign pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign push = rec_ok && (!fifo_full || pop);

  sent_cfg_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (push),
    .wr_data_i ({cfg_channel, cfg_param}),
    .rd_en_i   (pop),
    .rd_data_o ({head_ch, head_param}),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // One-hot decode of the held channel, used for ready selection and the load strobe
  always_comb begin
    hold_oh = '0;
    for (int i = 0; i < CH_NUM; i++) hold_oh[i] = (hold_ch_q == CH_W'(i));
  end

  assign ready_sel = |(ch_ready & hold_oh);
  assign wait_last = (wait_cnt_q == WAIT_LAST);
  // A boundary arriving on the last wait cycle still wins over the timeout
  assign timeout   = (state_q == ST_WAIT) && !ready_sel && wait_last;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ready_sel)      state_d = ST_LOAD;
        else if (wait_last) state_d = ST_IDLE;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: single-cycle reload strobe on the held channel
  always_comb begin
    ch_load = '0;
    if (state_q == ST_LOAD) ch_load = hold_oh;
  end

  // Holding register, wait counter and the externally visible parameter latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_ch_q    <= '0;
      hold_param_q <= '0;
      wait_cnt_q   <= '0;
      ch_param_q   <= '0;
    end else begin
      if (pop) begin
        hold_ch_q    <= head_ch;
        hold_param_q <= head_param;
        wait_cnt_q   <= '0;
      end else if ((state_q == ST_WAIT) && !ready_sel) begin
        wait_cnt_q <= wait_last ? '0 : wait_cnt_q + WAIT_W'(1);
      end
      if ((state_q == ST_WAIT) && (state_d == ST_LOAD)) ch_param_q <= hold_param_q;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
      ovf_q <= '0;
      tmo_q <= '0;
    end else begin
      if (cfg_vld && !rec_ok)                 err_q <= sat_inc(err_q);
      if (rec_ok && fifo_full && !pop)        ovf_q <= sat_inc(ovf_q);
      if (timeout)                            tmo_q <= sat_inc(tmo_q);
    end
  end

  assign ch_param = ch_param_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign err_cnt  = err_q;
  assign ovf_cnt  = ovf_q;
  assign tmo_cnt  = tmo_q;

endmodule

// File: tb/tb_sent_cfg_scheduler.sv
// tb/tb_sent_cfg_scheduler.sv - directed self-checking bench for sent_cfg_scheduler
module tb_sent_cfg_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_vld;
  logic [7:0]  cfg_channel;
  logic [65:0] cfg_param;
  logic [7:0]  ch_ready;
  logic [7:0]  ch_load;
  logic [65:0] ch_param;
  logic        busy;
  logic [15:0] err_cnt, ovf_cnt, tmo_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_send;

  logic [7:0]  lv_q[$];
  logic [65:0] lp_q[$];
  int          lc_q[$];

  sent_cfg_scheduler #(
    .CH_NUM      (8),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_vld     (cfg_vld),
    .cfg_channel (cfg_channel),
    .cfg_param   (cfg_param),
    .ch_ready    (ch_ready),
    .ch_load     (ch_load),
    .ch_param    (ch_param),
    .busy        (busy),
    .err_cnt     (err_cnt),
    .ovf_cnt     (ovf_cnt),
    .tmo_cnt     (tmo_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Load log, sampled mid-cycle
  always @(negedge clk) begin
    if (ch_load !== 8'h00) begin
      lv_q.push_back(ch_load);
      lp_q.push_back(ch_param);
      lc_q.push_back(cyc);
    end
  end

  function automatic logic [65:0] mkp(input logic [7:0] ct, input logic [7:0] lt, input logic [1:0] pm,
                                      input logic [15:0] pl, input logic [2:0] dl, input logic [23:0] d);
    return {ct, lt, pm, pl, 1'b1, 4'h9, dl, d};
  endfunction

  function automatic logic [65:0] vp(input logic [23:0] d);
    return mkp(8'd56, 8'd56, 2'd0, 16'd0, 3'd6, d);
  endfunction

  task automatic send(input logic [7:0] ch, input logic [65:0] p);
    cfg_vld     = 1'b1;
    cfg_channel = ch;
    cfg_param   = p;
    @(posedge clk);
    #1;
    cfg_vld   = 1'b0;
    last_send = cyc;
  endtask

  task automatic clear_log();
    lv_q.delete();
    lp_q.delete();
    lc_q.delete();
  endtask

  task automatic wait_loads(input int n, input int budget);
    int k = 0;
    while (lv_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_vld = 1'b0; cfg_channel = '0; cfg_param = '0; ch_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (ch_load !== 8'h00) begin failures++; $display("FAIL reset_ch_load got=%h exp=00", ch_load); end
    checks++; if (ch_param !== 66'd0) begin failures++; $display("FAIL reset_ch_param got=%h exp=0", ch_param); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
    checks++; if (tmo_cnt !== 16'd0) begin failures++; $display("FAIL reset_tmo got=%0d exp=0", tmo_cnt); end
  endtask

  task automatic test_single_load();
    logic [65:0] p;
    logic [7:0]  gv;
    logic [65:0] gp;
    int          gl;
    p = vp(24'hABC123);
    clear_log();
    ch_ready = 8'hFF;
    send(8'd2, p);
    wait_loads(1, 10);
    gv = (lv_q.size() > 0) ? lv_q[0] : 8'hxx;
    gp = (lp_q.size() > 0) ? lp_q[0] : 'x;
    // cfg_vld cycle t closes at last_send's edge; the load cycle opens two edges later (t+3)
    gl = (lc_q.size() > 0) ? lc_q[0] - last_send : -1;
    checks++; if (lv_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", lv_q.size()); end
    checks++; if (gv !== 8'h04) begin failures++; $display("FAIL single_ch_load got=%h exp=04", gv); end
    checks++; if (gp !== p) begin failures++; $display("FAIL single_param got=%h exp=%h", gp, p); end
    checks++; if (gl != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", gl); end
    checks++; if (ch_param !== p) begin failures++; $display("FAIL single_param_hold got=%h exp=%h", ch_param, p); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_invalid();
    int busy_hi = 0;
    clear_log();
    ch_ready = 8'hFF;
    send(8'd2, mkp(8'd2, 8'd56, 2'd0, 16'd0, 3'd6, 24'h1));
    if (busy !== 1'b0) busy_hi++;
    send(8'd2, mkp(8'd56, 8'd56, 2'd0, 16'd0, 3'd7, 24'h2));
    if (busy !== 1'b0) busy_hi++;
    send(8'd8, vp(24'h3));
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0) busy_hi++;
      @(posedge clk);
      #1;
    end
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL invalid_err got=%0d exp=3", err_cnt); end
    checks++; if (lv_q.size() != 0) begin failures++; $display("FAIL invalid_loads got=%0d exp=0", lv_q.size()); end
    checks++; if (busy_hi != 0) begin failures++; $display("FAIL invalid_busy got=%0d exp=0", busy_hi); end
  endtask

  task automatic test_limits();
    logic [7:0]  chs [6];
    logic [65:0] ps  [6];
    chs[0] = 8'd7; ps[0] = mkp(8'd3,  8'd56, 2'd0, 16'd0,   3'd6, 24'h10);
    chs[1] = 8'd0; ps[1] = mkp(8'd90, 8'd4,  2'd0, 16'd0,   3'd6, 24'h11);
    chs[2] = 8'd1; ps[2] = mkp(8'd56, 8'd56, 2'd0, 16'd0,   3'd1, 24'h12);
    chs[3] = 8'd3; ps[3] = mkp(8'd56, 8'd56, 2'd1, 16'd12,  3'd6, 24'h13);
    chs[4] = 8'd4; ps[4] = mkp(8'd56, 8'd56, 2'd1, 16'd768, 3'd6, 24'h14);
    chs[5] = 8'd5; ps[5] = mkp(8'd56, 8'd56, 2'd2, 16'd5,   3'd6, 24'h15);
    clear_log();
    ch_ready = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      send(chs[i], ps[i]);
      repeat (3) @(posedge clk);
      #1;
    end
    send(8'd0, mkp(8'd91, 8'd56, 2'd0, 16'd0,   3'd6, 24'h20));
    send(8'd0, mkp(8'd56, 8'd3,  2'd0, 16'd0,   3'd6, 24'h21));
    send(8'd0, mkp(8'd56, 8'd56, 2'd0, 16'd0,   3'd0, 24'h22));
    send(8'd0, mkp(8'd56, 8'd56, 2'd3, 16'd100, 3'd6, 24'h23));
    send(8'd0, mkp(8'd56, 8'd56, 2'd1, 16'd11,  3'd6, 24'h24));
    send(8'd0, mkp(8'd56, 8'd56, 2'd1, 16'd769, 3'd6, 24'h25));
    wait_loads(6, 10);
    checks++; if (lv_q.size() != 6) begin failures++; $display("FAIL limits_count got=%0d exp=6", lv_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < lv_q.size()) begin
        checks++;
        if (lv_q[i] !== (8'h01 << chs[i]) || lp_q[i] !== ps[i]) begin
          failures++;
          $display("FAIL limits_load%0d got=%h/%h exp=%h/%h", i, lv_q[i], lp_q[i], 8'h01 << chs[i], ps[i]);
        end
      end
    end
    checks++; if (err_cnt !== 16'd9) begin failures++; $display("FAIL limits_err got=%0d exp=9", err_cnt); end
    checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("FAIL limits_ovf got=%0d exp=0", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  chs [6];
    logic [65:0] ps  [6];
    chs[0] = 8'd3; chs[1] = 8'd1; chs[2] = 8'd4; chs[3] = 8'd0; chs[4] = 8'd5; chs[5] = 8'd2;
    for (int i = 0; i < 6; i++) ps[i] = vp(24'h300 + 24'(i));
    clear_log();
    ch_ready = 8'h00;
    for (int i = 0; i < 6; i++) send(chs[i], ps[i]);
    checks++; if (ovf_cnt !== 16'd1) begin failures++; $display("FAIL b2b_ovf got=%0d exp=1", ovf_cnt); end
    checks++; if (lv_q.size() != 0) begin failures++; $display("FAIL b2b_early_loads got=%0d exp=0", lv_q.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    ch_ready = 8'hFF;
    wait_loads(5, 40);
    checks++; if (lv_q.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", lv_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < lv_q.size()) begin
        checks++;
        if (lv_q[i] !== (8'h01 << chs[i]) || lp_q[i] !== ps[i]) begin
          failures++;
          $display("FAIL b2b_load%0d got=%h/%h exp=%h/%h", i, lv_q[i], lp_q[i], 8'h01 << chs[i], ps[i]);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    logic [65:0] pa, pb;
    logic [7:0]  gv;
    logic [65:0] gp;
    pa = vp(24'h400);
    pb = vp(24'h401);
    clear_log();
    ch_ready = 8'hFD;
    send(8'd1, pa);
    send(8'd0, pb);
    // Held record is in WAIT from one edge after its write; 16 WAIT cycles end at edge 17
    repeat (15) @(posedge clk);
    #1;
    checks++; if (tmo_cnt !== 16'd0) begin failures++; $display("FAIL tmo_early got=%0d exp=0", tmo_cnt); end
    @(posedge clk);
    #1;
    checks++; if (tmo_cnt !== 16'd1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", tmo_cnt); end
    wait_loads(1, 10);
    gv = (lv_q.size() > 0) ? lv_q[0] : 8'hxx;
    gp = (lp_q.size() > 0) ? lp_q[0] : 'x;
    checks++; if (lv_q.size() != 1) begin failures++; $display("FAIL tmo_loads got=%0d exp=1", lv_q.size()); end
    checks++; if (gv !== 8'h01) begin failures++; $display("FAIL tmo_next_ch got=%h exp=01", gv); end
    checks++; if (gp !== pb) begin failures++; $display("FAIL tmo_next_param got=%h exp=%h", gp, pb); end
  endtask

  task automatic test_reset_mid_wait();
    clear_log();
    ch_ready = 8'h00;
    for (int i = 0; i < 4; i++) send(8'(i), vp(24'h500 + 24'(i)));
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstw_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ch_ready = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (lv_q.size() != 0) begin failures++; $display("FAIL rstw_loads got=%0d exp=0", lv_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b exp=0", busy); end
    checks++; if (ch_param !== 66'd0) begin failures++; $display("FAIL rstw_param got=%h exp=0", ch_param); end
    checks++;
    if ({err_cnt, ovf_cnt, tmo_cnt} !== 48'd0) begin
      failures++;
      $display("FAIL rstw_counters got=%0d/%0d/%0d exp=0/0/0", err_cnt, ovf_cnt, tmo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_invalid();
    test_limits();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
